// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_pkg;

    // Address width for a memory of the given depth (at least one bit).
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Ownership states of the arbiter.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    // Requester indices: core load/store path and DMA/debug loader.
    localparam int REQ_CORE = 0;
    localparam int REQ_DMA  = 1;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic [1:0] i_allow,
    output logic [1:0] o_gnt
);

    logic [1:0] w_elig;

    assign w_elig = i_req & i_allow;

    // One-hot pick; on a tie the requester that did not win last time goes.
    always_comb begin
        o_gnt = w_elig;
        if (w_elig == 2'b11) begin
            o_gnt = i_last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter and sequencer for the data memory
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter  int DEPTH  = 32,
    parameter  int WIDTH  = 32,
    localparam int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  wdata0,
    input  logic [WIDTH-1:0]  wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [WIDTH-1:0]  rdata0,
    output logic [WIDTH-1:0]  rdata1,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last;
    logic              w_last_nxt;
    logic [1:0]        w_allow;
    logic [1:0]        w_pick;
    logic [1:0]        w_gnt;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [WIDTH-1:0]  r_rdata0;
    logic [WIDTH-1:0]  r_rdata1;
    logic              w_rd0;
    logic              w_rd1;

    // Only the owner may be picked while a lock is held.
    always_comb begin
        w_allow = 2'b11;
        case (r_state)
            ST_OWN0: w_allow = 2'b01;
            ST_OWN1: w_allow = 2'b10;
            default: w_allow = 2'b11;
        endcase
    end

    rr_pick2 u_pick (
        .i_req   ({req1, req0}),
        .i_last  (r_last),
        .i_allow (w_allow),
        .o_gnt   (w_pick)
    );

    // Reset suppresses every grant so nothing reaches memory in that cycle.
    assign w_gnt = rst ? 2'b00 : w_pick;

    assign gnt0      = w_gnt[REQ_CORE];
    assign gnt1      = w_gnt[REQ_DMA];
    assign mem_write = (w_gnt[REQ_CORE] & we0) | (w_gnt[REQ_DMA] & we1);
    assign mem_addr  = w_gnt[REQ_DMA] ? addr1  : addr0;
    assign mem_wdata = w_gnt[REQ_DMA] ? wdata1 : wdata0;

    assign w_rd0 = w_gnt[REQ_CORE] & ~we0;
    assign w_rd1 = w_gnt[REQ_DMA]  & ~we1;

    // Next ownership state and round-robin pointer.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        if (w_gnt[REQ_CORE]) begin
            w_last_nxt = 1'b0;
        end else if (w_gnt[REQ_DMA]) begin
            w_last_nxt = 1'b1;
        end
        case (r_state)
            ST_IDLE: begin
                if (w_gnt[REQ_CORE] && lock0) begin
                    w_state_nxt = ST_OWN0;
                end else if (w_gnt[REQ_DMA] && lock1) begin
                    w_state_nxt = ST_OWN1;
                end
            end
            // Owner keeps the memory only by requesting again with lock set.
            ST_OWN0: begin
                if (!(w_gnt[REQ_CORE] && lock0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (!(w_gnt[REQ_DMA] && lock1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, pointer and read-response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_last    <= 1'b1;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_rvalid0 <= w_rd0;
            r_rvalid1 <= w_rd1;
            if (w_rd0) begin
                r_rdata0 <= mem_rdata;
            end
            if (w_rd1) begin
                r_rdata1 <= mem_rdata;
            end
        end
    end

    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a reference model
module tb_dmem_arbiter;

    localparam int DEPTH = 32;
    localparam int WIDTH = 32;
    localparam int AW    = 5;

    logic             clk;
    logic             rst;
    logic             req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0]    addr0, addr1;
    logic [WIDTH-1:0] wdata0, wdata1;
    logic             gnt0, gnt1, rvalid0, rvalid1;
    logic [WIDTH-1:0] rdata0, rdata1;
    logic             mem_write;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    dmem_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Data memory: synchronous write, combinational read.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: owner (-1 none), last winner, memory image, responses.
    int               m_owner = -1;
    int               m_last  = 1;
    logic [WIDTH-1:0] m_mem [DEPTH];
    logic             e_rv0 = 1'b0, e_rv1 = 1'b0;
    logic [WIDTH-1:0] e_rd0 = '0, e_rd1 = '0;

    logic s_gnt0, s_gnt1, s_mw;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        if (rst) return -1;
        if (m_owner == 0) return req0 ? 0 : -1;
        if (m_owner == 1) return req1 ? 1 : -1;
        if (req0 && req1) return (m_last == 0) ? 1 : 0;
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    // One clock: check combinational outputs, clock, update model, check responses.
    task automatic step();
        int   g;
        logic ew;
        #1;
        g  = model_grant();
        ew = (g == 0 && we0) || (g == 1 && we1);
        s_gnt0 = gnt0;
        s_gnt1 = gnt1;
        s_mw   = mem_write;
        check("gnt0", {31'd0, gnt0}, {31'd0, g == 0});
        check("gnt1", {31'd0, gnt1}, {31'd0, g == 1});
        check("mem_write", {31'd0, mem_write}, {31'd0, ew});
        check("mem_addr", {27'd0, mem_addr}, {27'd0, (g == 1) ? addr1 : addr0});
        if (ew) check("mem_wdata", mem_wdata, (g == 1) ? wdata1 : wdata0);
        @(posedge clk);
        if (rst) begin
            m_owner = -1;
            m_last  = 1;
            e_rv0 = 1'b0; e_rv1 = 1'b0;
            e_rd0 = '0;   e_rd1 = '0;
        end else begin
            e_rv0 = (g == 0) && !we0;
            e_rv1 = (g == 1) && !we1;
            if (e_rv0) e_rd0 = m_mem[addr0];
            if (e_rv1) e_rd1 = m_mem[addr1];
            if (g == 0 && we0) m_mem[addr0] = wdata0;
            if (g == 1 && we1) m_mem[addr1] = wdata1;
            if (g >= 0) begin
                m_last  = g;
                m_owner = ((g == 0) ? lock0 : lock1) ? g : -1;
            end else begin
                m_owner = -1;
            end
        end
        #1;
        check("rvalid0", {31'd0, rvalid0}, {31'd0, e_rv0});
        check("rvalid1", {31'd0, rvalid1}, {31'd0, e_rv1});
        check("rdata0", rdata0, e_rd0);
        check("rdata1", rdata1, e_rd1);
        @(negedge clk);
    endtask

    task automatic set0(input logic r, input logic w, input logic l,
                        input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic l,
                        input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
    endtask

    task automatic rand0();
        set0(($urandom % 4) != 0, 1'($urandom % 2), ($urandom % 4) == 0,
             AW'($urandom % DEPTH), $urandom);
    endtask

    task automatic rand1();
        set1(($urandom % 4) != 0, 1'($urandom % 2), ($urandom % 4) == 0,
             AW'($urandom % DEPTH), $urandom);
    endtask

    logic [WIDTH-1:0] keep3;

    initial begin
        rst = 1'b1;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        @(negedge clk);

        // Reset, then a single write and read-back.
        step();
        step();
        check("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        rst = 1'b0;
        set0(1, 1, 0, 5, 33);
        step();
        check("p1_wr_gnt0", {31'd0, s_gnt0}, 32'd1);
        check("p1_wr_mw", {31'd0, s_mw}, 32'd1);
        set0(1, 0, 0, 5, 0);
        step();
        check("p1_rd_gnt0", {31'd0, s_gnt0}, 32'd1);
        check("p1_rvalid0", {31'd0, rvalid0}, 32'd1);
        check("p1_rdata0", rdata0, 32'd33);

        // Fill the whole memory so later reads have known contents.
        for (int a = 0; a < DEPTH; a++) begin
            set0(1, 1, 0, AW'(a), $urandom);
            step();
        end
        set0(0, 0, 0, 0, 0);

        // Contention: alternating grants after reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        set0(1, 0, 0, 1, 0);
        set1(1, 0, 0, 2, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("p2_gnt0", {31'd0, s_gnt0}, {31'd0, (i % 2) == 0});
            check("p2_gnt1", {31'd0, s_gnt1}, {31'd0, (i % 2) == 1});
            if ((i % 2) == 0) check("p2_rdata0", rdata0, m_mem[1]);
            else              check("p2_rdata1", rdata1, m_mem[2]);
        end

        // Locked burst from requester 1 while requester 0 keeps asking.
        set1(0, 0, 0, 0, 0);
        set0(1, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            set1(1, 1, k < 2, AW'(8 + k), 32'hA + k);
            step();
            check("p3_gnt1", {31'd0, s_gnt1}, 32'd1);
            check("p3_gnt0", {31'd0, s_gnt0}, 32'd0);
        end
        set1(0, 0, 0, 0, 0);
        step();
        check("p3_release_gnt0", {31'd0, s_gnt0}, 32'd1);
        set0(0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            set1(1, 0, 0, AW'(8 + k), 0);
            step();
            check("p3_readback", rdata1, 32'hA + k);
        end

        // Lock abandoned by requester 0.
        set1(0, 0, 0, 0, 0);
        set0(1, 1, 1, 4, 32'h44);
        step();
        check("p4_gnt0", {31'd0, s_gnt0}, 32'd1);
        set0(0, 0, 0, 0, 0);
        set1(1, 0, 0, 8, 0);
        step();
        check("p4_idle_gnt1", {31'd0, s_gnt1}, 32'd0);
        step();
        check("p4_gnt1", {31'd0, s_gnt1}, 32'd1);

        // Reset in the middle of a requester-1 burst.
        set1(1, 1, 1, 20, 32'h77);
        step();
        keep3 = mem[3];
        set1(1, 1, 1, 3, 32'h55);
        rst = 1'b1;
        step();
        check("p5_gnt1", {31'd0, s_gnt1}, 32'd0);
        check("p5_mw", {31'd0, s_mw}, 32'd0);
        check("p5_rvalid1", {31'd0, rvalid1}, 32'd0);
        check("p5_mem3", mem[3], keep3);
        rst = 1'b0;
        set0(1, 0, 0, 1, 0);
        set1(1, 0, 0, 2, 0);
        step();
        check("p5_tie_gnt0", {31'd0, s_gnt0}, 32'd1);

        // Write followed immediately by a read of the same word.
        set0(1, 1, 0, 7, 32'h1234);
        set1(0, 0, 0, 0, 0);
        step();
        set0(0, 0, 0, 0, 0);
        set1(1, 0, 0, 7, 0);
        step();
        check("p6_rvalid1", {31'd0, rvalid1}, 32'd1);
        check("p6_rdata1", rdata1, 32'h1234);

        // Random traffic; a requester holds its operation until granted.
        rand0();
        rand1();
        for (int c = 0; c < 500; c++) begin
            rst = (($urandom % 64) == 0);
            step();
            if (s_gnt0 || !req0) rand0();
            if (s_gnt1 || !req1) rand1();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory (1 shared address, 1 write port, synchronous write, combinational read).
- Requester 0 is the core load/store path; requester 1 is the DMA/debug loader.
- Grants at most one access per cycle, round-robin on contention, with an optional lock for multi-word bursts.
- Registers read data back to the winning requester.

Parameters:
- DEPTH, 32, number of memory words; address width ADDR_W = $clog2(DEPTH) (localparam).
- WIDTH, 32, data word width in bits.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req0, req1  in  1  access request from requester 0 / 1.
- we0, we1  in  1  1 = write, 0 = read; qualified by reqN.
- lock0, lock1  in  1  hold ownership after this access; qualified by reqN.
- addr0, addr1  in  ADDR_W  word address.
- wdata0, wdata1  in  WIDTH  write data.
- gnt0, gnt1  out  1  combinational grant; access is performed in this cycle.
- rvalid0, rvalid1  out  1  registered; read data valid, 1 cycle after a granted read.
- rdata0, rdata1  out  WIDTH  registered read data.
- mem_write  out  1  to memory write enable.
- mem_addr  out  ADDR_W  to memory address.
- mem_wdata  out  WIDTH  to memory write data.
- mem_rdata  in  WIDTH  from memory, combinational read of mem_addr.

Behaviour:
- State machine: IDLE, OWN0, OWN1. State register plus priority pointer `last` (last requester granted, 1 bit).
- IDLE, grant rule:
  - Only reqN set: grant N.
  - Both set: grant the requester != last.
  - Neither set: no grant.
- OWNn: only requester n may be granted. The other requester's gnt is 0 even if it requests.
- Transitions:
  - Granted access with lockN=1 goes to OWNn.
  - From OWNn, go to IDLE on a granted access with lock_n=0, or on any cycle with req_n=0. On that req_n=0 cycle, no grant is given to either requester; the other requester is eligible next cycle.
  - `last` updates to N on every grant.
- Outputs (combinational):
  - gnt0 & gnt1 is never 1 in the same cycle.
  - mem_addr / mem_wdata are muxed from the granted requester.
  - With no grant, mem_addr = addr0 and mem_wdata = wdata0; this is don't-care for reads.
  - mem_write = (gnt0 & we0) | (gnt1 & we1). Memory write occurs at the posedge ending the grant cycle.
- Read response:
  - On posedge, rvalidN <= gntN & ~weN.
  - If gntN & ~weN, rdataN <= mem_rdata; otherwise rdataN holds its value.
  - Read latency is 1 cycle from grant.
  - Write-then-read to the same address in consecutive cycles returns the newly written data.
- Reset (rst=1 at posedge):
  - State = IDLE, last = 1 (requester 0 wins the first tie), rvalid0/1 = 0, rdata0/1 = 0.
  - While rst is asserted, gnt0/1 and mem_write are forced to 0 combinationally.
  - Reset mid-burst drops the lock; no write occurs in the reset cycle.
- A requester keeps reqN and its operands stable until it sees gntN. A losing requester simply retries next cycle; there is no queuing.
- Burst length is unbounded, and starvation during a lock is the owner's responsibility.

Decomposition:
- Shared package dmem_pkg holds:
  - ADDR_W derivation helper.
  - State encoding constants ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2.
  - Requester index constants REQ_CORE=0, REQ_DMA=1.
- One natural sub-module: rr_pick2, a combinational 2-way round-robin picker (inputs req[1:0], last, allowed mask; output one-hot grant).
- Response registers and the FSM stay in dmem_arbiter.
- Bench instantiates dmem_arbiter plus the existing data memory with matching DEPTH/WIDTH.

Test Plan:
1. Reset then single access: rst 2 cycles, then req0=1, we0=1, addr0=5, wdata0=33 for 1 cycle.
   - Expect gnt0=1, mem_write=1 that cycle.
   - Next cycle: req0=1, we0=0, addr0=5 gives gnt0=1; the following cycle rvalid0=1, rdata0=33.
2. Contention round-robin: req0=req1=1, both reads, addr0=1, addr1=2, held 4 cycles after reset.
   - Grants alternate gnt0, gnt1, gnt0, gnt1.
   - rvalid alternates one cycle later with rdata = mem[1], mem[2].
3. Locked burst: req1=1, lock1=1 writing addr 8,9,10 (data 0xA,0xB,0xC) while req0=1 continuously.
   - gnt1 for 3 cycles, gnt0=0 throughout.
   - Last beat with lock1=0 releases; gnt0=1 next cycle.
   - Readback of 8..10 returns 0xA..0xC.
4. Lock abandoned: req0=1, lock0=1 for 1 grant, then req0=0 while req1=1.
   - One idle cycle with no grant, then gnt1=1.
5. Reset mid-burst: during OWN1 with req1=1, we1=1, addr1=3, wdata1=0x55, assert rst for 1 cycle.
   - gnt1=0, mem_write=0, mem[3] unchanged; rvalid0/1=0.
   - After reset, a tie grants requester 0 first.
6. Write-then-read hazard: gnt0 write addr 7 = 0x1234, next cycle gnt1 read addr 7.
   - rvalid1=1, rdata1=0x1234 one cycle later.
